// File: rtl/host_bus_master.sv
// -----------------------------------------------------------------------------
// host_bus_master
//   Host-side initiator for the accelerator's memory-mapped control bus.
//   Turns single-beat word commands (read or write) into ordered handshakes on
//   the AW/W (write) or AR/R (read) channels, then presents one response.
//
// Ports
//   clk, n_rst                 clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready        command handshake; cmd_write, cmd_addr, cmd_wdata
//   rsp_valid/rsp_ready        response handshake; rsp_write, rsp_err, rsp_data
//   busy                       high whenever a command is in flight or unanswered
//   AWVALID/AWADDR/AWREADY     write-address channel
//   WDVALID/WDATA/WDREADY      write-data channel (write completes here)
//   ARVALID/ARADDR/ARREADY     read-address channel
//   RDREADY/RDVALID/RDATA      read-data channel
//
// Parameters
//   TIMEOUT_CYCLES  max cycles spent waiting on any one channel handshake
//                   (0 disables the timeout)
//   TCNT_W          timeout counter width; TIMEOUT_CYCLES < 2**TCNT_W
// -----------------------------------------------------------------------------
module host_bus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned TCNT_W         = 16
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_write,
  output logic        rsp_err,
  output logic [31:0] rsp_data,
  output logic        busy,
  output logic        AWVALID,
  output logic [31:0] AWADDR,
  input  logic        AWREADY,
  output logic        WDVALID,
  output logic [31:0] WDATA,
  input  logic        WDREADY,
  output logic        ARVALID,
  output logic [31:0] ARADDR,
  input  logic        ARREADY,
  output logic        RDREADY,
  input  logic        RDVALID,
  input  logic [31:0] RDATA
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4,
    RESP    = 3'd5
  } state_e;

  localparam bit                TO_EN  = (TIMEOUT_CYCLES != 0);
  localparam logic [TCNT_W-1:0] TLIMIT = TCNT_W'(TIMEOUT_CYCLES - 32'd1);

  state_e             state_q, state_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               write_q, write_d;
  logic               err_q, err_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [TCNT_W-1:0]  tcnt_q, tcnt_d;
  // Holds cmd_ready low while reset is asserted and for the first edge after
  // release, so the command port only opens once the block is clocking.
  logic               rdy_en_q;

  logic               chan_st;     // in one of the four channel-wait states
  logic               hs;          // the active channel handshakes this edge
  state_e             hs_state;    // where that handshake takes us
  logic               timeout_hit;

  assign timeout_hit = TO_EN && (tcnt_q == TLIMIT);

  // NOTE: every variable gets a default before the case statement so no path
  // leaves one unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    write_d  = write_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    tcnt_d   = tcnt_q;
    chan_st  = 1'b0;
    hs       = 1'b0;
    hs_state = IDLE;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid && rdy_en_q) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_write ? cmd_wdata : '0;
          write_d = cmd_write;
          err_d   = 1'b0;
          rdata_d = '0;
          tcnt_d  = '0;
          state_d = cmd_write ? WR_ADDR : RD_ADDR;
        end
      end
      WR_ADDR: begin
        chan_st  = 1'b1;
        hs       = AWREADY;
        hs_state = WR_DATA;
      end
      WR_DATA: begin
        chan_st  = 1'b1;
        hs       = WDREADY;
        hs_state = RESP;
      end
      RD_ADDR: begin
        chan_st  = 1'b1;
        hs       = ARREADY;
        hs_state = RD_DATA;
      end
      RD_DATA: begin
        chan_st  = 1'b1;
        hs       = RDVALID;
        hs_state = RESP;
        if (RDVALID) rdata_d = RDATA;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Shared wait/timeout handling; a handshake on the limit edge still wins.
    if (chan_st) begin
      if (hs) begin
        state_d = hs_state;
        tcnt_d  = '0;
      end else if (timeout_hit) begin
        state_d = RESP;
        err_d   = 1'b1;
        rdata_d = '0;
      end else begin
        tcnt_d = tcnt_q + TCNT_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      tcnt_q   <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      write_q  <= write_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      tcnt_q   <= tcnt_d;
      rdy_en_q <= 1'b1;
    end
  end

  // Outputs decode straight from the state register, so an async reset
  // drops them without waiting for a clock edge.
  assign cmd_ready = (state_q == IDLE) && rdy_en_q;
  assign busy      = (state_q != IDLE);
  assign AWVALID   = (state_q == WR_ADDR);
  assign WDVALID   = (state_q == WR_DATA);
  assign ARVALID   = (state_q == RD_ADDR);
  assign RDREADY   = (state_q == RD_DATA);
  assign rsp_valid = (state_q == RESP);
  assign AWADDR    = addr_q;
  assign ARADDR    = addr_q;
  assign WDATA     = wdata_q;
  assign rsp_write = write_q;
  assign rsp_err   = err_q;
  assign rsp_data  = rdata_q;

endmodule

// File: tb/tb_host_bus_master.sv
// -----------------------------------------------------------------------------
// tb_host_bus_master
//   Self-checking bench for host_bus_master (TIMEOUT_CYCLES = 8).
//   A bus responder with programmable per-channel delays answers the DUT and
//   keeps a word memory; a transaction-level model predicts response latency,
//   error and data from the delays alone.
// -----------------------------------------------------------------------------
module tb_host_bus_master;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_write, rsp_err;
  logic [31:0] rsp_data;
  logic        busy;
  logic        AWVALID, WDVALID, ARVALID, RDREADY;
  logic [31:0] AWADDR, WDATA, ARADDR;
  logic        AWREADY = 1'b0;
  logic        WDREADY = 1'b0;
  logic        ARREADY = 1'b0;
  logic        RDVALID = 1'b0;
  logic [31:0] RDATA   = '0;

  host_bus_master #(.TIMEOUT_CYCLES(T), .TCNT_W(4)) dut (
    .clk(clk), .n_rst(n_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_err(rsp_err), .rsp_data(rsp_data), .busy(busy),
    .AWVALID(AWVALID), .AWADDR(AWADDR), .AWREADY(AWREADY),
    .WDVALID(WDVALID), .WDATA(WDATA), .WDREADY(WDREADY),
    .ARVALID(ARVALID), .ARADDR(ARADDR), .ARREADY(ARREADY),
    .RDREADY(RDREADY), .RDVALID(RDVALID), .RDATA(RDATA)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- responder ----------------
  // Delay d: READY/RDVALID rises after d waiting cycles (VALID held d+1
  // cycles); a negative delay never answers.
  int aw_dly = 0, w_dly = 0, ar_dly = 0, r_dly = 0;
  bit spur_en = 1'b0;
  int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, r_cnt = 0;
  int last_aw_len = 0, last_r_len = 0, w_cycles = 0, viol = 0;
  bit aw_seen = 1'b0;
  bit p_awv = 1'b0, p_wv = 1'b0, p_arv = 1'b0, p_rr = 1'b0;
  logic [31:0] p_awaddr = '0, p_wdata = '0, p_araddr = '0;
  logic [31:0] aw_addr_l = '0, ar_addr_l = '0;
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] rd_value(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : ~a;
  endfunction

  always @(negedge clk) begin
    if (!n_rst) begin
      AWREADY = 1'b0; WDREADY = 1'b0; ARREADY = 1'b0; RDVALID = 1'b0; RDATA = '0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_cnt = 0;
      aw_seen = 1'b0; p_awv = 1'b0; p_wv = 1'b0; p_arv = 1'b0; p_rr = 1'b0;
    end else begin
      // handshakes that happened on the rising edge just passed
      if (p_awv && AWREADY) begin aw_seen = 1'b1; aw_addr_l = p_awaddr; end
      if (p_wv && WDREADY) begin
        if (!aw_seen) viol++;
        mem[aw_addr_l] = p_wdata;
        aw_seen = 1'b0;
      end
      if (p_arv && ARREADY) ar_addr_l = p_araddr;
      // protocol rules
      if ($countones({AWVALID, WDVALID, ARVALID, RDREADY, rsp_valid}) > 1) viol++;
      if (WDVALID && !p_wv && !aw_seen) viol++;
      if (p_awv && AWVALID && AWADDR !== p_awaddr) viol++;
      if (p_wv && WDVALID && WDATA !== p_wdata) viol++;
      if (p_arv && ARVALID && ARADDR !== p_araddr) viol++;
      if (WDVALID) w_cycles++;
      // drive readies for the coming edge
      if (AWVALID) begin
        AWREADY = (aw_dly >= 0) && (aw_cnt >= aw_dly); aw_cnt++;
      end else begin
        if (p_awv) last_aw_len = aw_cnt;
        aw_cnt = 0; AWREADY = spur_en && ($urandom_range(0, 1) == 1);
      end
      if (WDVALID) begin
        WDREADY = (w_dly >= 0) && (w_cnt >= w_dly); w_cnt++;
      end else begin
        w_cnt = 0; WDREADY = spur_en && ($urandom_range(0, 1) == 1);
      end
      if (ARVALID) begin
        ARREADY = (ar_dly >= 0) && (ar_cnt >= ar_dly); ar_cnt++;
      end else begin
        ar_cnt = 0; ARREADY = spur_en && ($urandom_range(0, 1) == 1);
      end
      if (RDREADY) begin
        RDVALID = (r_dly >= 0) && (r_cnt >= r_dly);
        RDATA   = RDVALID ? rd_value(ar_addr_l) : $urandom;
        r_cnt++;
      end else begin
        if (p_rr) last_r_len = r_cnt;
        r_cnt = 0; RDVALID = spur_en && ($urandom_range(0, 1) == 1); RDATA = $urandom;
      end
      p_awv = AWVALID; p_awaddr = AWADDR;
      p_wv  = WDVALID; p_wdata  = WDATA;
      p_arv = ARVALID; p_araddr = ARADDR;
      p_rr  = RDREADY;
    end
  end

  // ---------------- transaction model ----------------
  typedef struct {
    string       name;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          d0;        // address-channel delay
    int          d1;        // data-channel delay
    int          stall;     // cycles rsp_ready is held low
    bit          exp_err;
    logic [31:0] exp_data;
    int          exp_lat;   // cycles from accept edge to first rsp_valid cycle
  } vec_t;

  logic [31:0] model_mem [logic [31:0]];
  int last_accept = 0;

  // One cycle to leave IDLE, then each channel phase costs its wait plus one,
  // or exactly T cycles if the responder is too slow (error, rest skipped).
  function automatic void model(inout vec_t v);
    int lat = 1;
    bit err = 1'b0;
    int ph[2];
    ph[0] = v.d0; ph[1] = v.d1;
    for (int i = 0; i < 2; i++) begin
      if (ph[i] >= 0 && ph[i] < T) lat += ph[i] + 1;
      else begin lat += T; err = 1'b1; break; end
    end
    v.exp_err  = err;
    v.exp_lat  = lat;
    v.exp_data = (err || v.wr) ? 32'h0
               : (model_mem.exists(v.addr) ? model_mem[v.addr] : ~v.addr);
  endfunction

  // Called at a falling edge with the DUT idle; returns at a falling edge
  // one cycle after the response handshake.
  task automatic run_vec(input vec_t v);
    int n;
    aw_dly = v.wr ? v.d0 : -1;
    w_dly  = v.wr ? v.d1 : -1;
    ar_dly = v.wr ? -1 : v.d0;
    r_dly  = v.wr ? -1 : v.d1;
    cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata;
    check({v.name, ".cmd_ready"}, 32'(cmd_ready), 32'd1);
    @(posedge clk);
    last_accept = cyc;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_write = 1'($urandom_range(0, 1));
    cmd_addr = $urandom; cmd_wdata = $urandom;
    n = 1;
    while (!rsp_valid && n < 40) begin @(negedge clk); n++; end
    check({v.name, ".lat"},   32'(n),         32'(v.exp_lat));
    check({v.name, ".err"},   32'(rsp_err),   32'(v.exp_err));
    check({v.name, ".write"}, 32'(rsp_write), 32'(v.wr));
    check({v.name, ".data"},  rsp_data,       v.exp_data);
    for (int s = 0; s < v.stall; s++) begin
      cmd_valid = 1'b1;   // a decoy command that must not be taken
      @(negedge clk);
      check({v.name, ".stall_ctl"}, 32'({rsp_valid, cmd_ready, rsp_err, rsp_write}),
            32'({1'b1, 1'b0, v.exp_err, v.wr}));
      check({v.name, ".stall_data"}, rsp_data, v.exp_data);
    end
    rsp_ready = 1'b1; cmd_valid = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({v.name, ".after_rsp"}, 32'({rsp_valid, cmd_ready}), 32'b01);
    if (v.wr && !v.exp_err) model_mem[v.addr] = v.wdata;
  endtask

  function automatic int pick_dly();
    int r = int'($urandom_range(0, 9));
    if (r < 6) return int'($urandom_range(0, 3));
    if (r < 9) return int'($urandom_range(4, 9));
    return -1;
  endfunction

  // ---------------- test sequence ----------------
  vec_t tbl[$];
  vec_t v;
  int   acc0, wb, n;
  bit   seen;

  initial begin
    n_rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; rsp_ready = 1'b0;
    #1 n_rst = 1'b0;
    repeat (2) @(negedge clk);

    // reset state
    check("rst.valids", 32'({cmd_ready, rsp_valid, busy, AWVALID, WDVALID, ARVALID, RDREADY}), 32'd0);
    check("rst.rsp", 32'({rsp_err, rsp_write}), 32'd0);
    check("rst.awaddr", AWADDR, 32'd0);
    check("rst.wdata", WDATA, 32'd0);
    check("rst.araddr", ARADDR, 32'd0);
    check("rst.rsp_data", rsp_data, 32'd0);
    n_rst = 1'b1;
    check("rst.release_ready_low", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    check("rst.release_ready", 32'(cmd_ready), 32'd1);

    // directed vectors: name, wr, addr, wdata, d0, d1, stall, err, data, lat
    tbl.push_back('{"wr_zero",  1'b1, 32'h10, 32'hCAFE_F00D, 0, 0, 0, 1'b0, 32'h0, 3});
    tbl.push_back('{"wr_40",    1'b1, 32'h40, 32'h1234_5678, 0, 0, 0, 1'b0, 32'h0, 3});
    tbl.push_back('{"rd_wait",  1'b0, 32'h40, 32'h0, 3, 2, 0, 1'b0, 32'h1234_5678, 8});
    tbl.push_back('{"wr_lim7",  1'b1, 32'h84, 32'h1111_2222, 7, 7, 0, 1'b0, 32'h0, 17});
    tbl.push_back('{"rd_lim7",  1'b0, 32'h84, 32'h0, 7, 7, 0, 1'b0, 32'h1111_2222, 17});
    tbl.push_back('{"wr_to_w",  1'b1, 32'h88, 32'h3333_4444, 0, 8, 0, 1'b1, 32'h0, 10});
    tbl.push_back('{"rd_88",    1'b0, 32'h88, 32'h0, 0, 0, 0, 1'b0, 32'hFFFF_FF77, 3});
    tbl.push_back('{"rd_to_ar", 1'b0, 32'h10, 32'h0, 8, 0, 0, 1'b1, 32'h0, 9});
    tbl.push_back('{"rd_stall", 1'b0, 32'h10, 32'h0, 1, 0, 5, 1'b0, 32'hCAFE_F00D, 4});
    tbl.push_back('{"wr_stall", 1'b1, 32'h8C, 32'h5, 1, 2, 3, 1'b0, 32'h0, 6});
    tbl.push_back('{"rd_8c",    1'b0, 32'h8C, 32'h0, 2, 1, 1, 1'b0, 32'h5, 6});
    foreach (tbl[i]) run_vec(tbl[i]);

    // timeout on a stuck AWREADY: AWVALID for exactly T cycles, no W phase
    wb = w_cycles;
    v = '{"to_aw", 1'b1, 32'h90, 32'hDEAD_0001, -1, 0, 0, 1'b1, 32'h0, 9};
    run_vec(v);
    check("to_aw.aw_len", 32'(last_aw_len), 32'(T));
    check("to_aw.no_w", 32'(w_cycles - wb), 32'd0);

    // timeout on a stuck RDVALID: RDREADY for exactly T cycles
    v = '{"to_r", 1'b0, 32'h10, 32'h0, 0, -1, 0, 1'b1, 32'h0, 10};
    run_vec(v);
    check("to_r.r_len", 32'(last_r_len), 32'(T));

    // back-to-back write then read of the same word, 4-cycle period
    v = '{"b2b_wr", 1'b1, 32'h100, 32'hA, 0, 0, 0, 1'b0, 32'h0, 3};
    run_vec(v);
    acc0 = last_accept;
    v = '{"b2b_rd", 1'b0, 32'h100, 32'h0, 0, 0, 0, 1'b0, 32'hA, 3};
    run_vec(v);
    check("b2b.period", 32'(last_accept - acc0), 32'd4);

    // randomized traffic with spurious READY/VALID noise
    spur_en = 1'b1;
    for (int i = 0; i < 60; i++) begin
      v.name  = $sformatf("rnd%0d", i);
      v.wr    = 1'($urandom_range(0, 1));
      v.addr  = 32'h200 + 32'(4 * $urandom_range(0, 7));
      v.wdata = $urandom;
      v.d0    = pick_dly();
      v.d1    = pick_dly();
      v.stall = int'($urandom_range(0, 3));
      model(v);
      run_vec(v);
    end
    spur_en = 1'b0;

    // async reset in the middle of the W phase
    aw_dly = 0; w_dly = -1; ar_dly = -1; r_dly = -1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h300; cmd_wdata = 32'h55AA_55AA;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!WDVALID && n < 10) begin @(negedge clk); n++; end
    check("arst.in_wdata", 32'(WDVALID), 32'd1);
    #2 n_rst = 1'b0;
    #1 check("arst.drop", 32'({WDVALID, busy, rsp_valid}), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    check("arst.ready", 32'(cmd_ready), 32'd1);
    seen = 1'b0;
    repeat (5) begin @(negedge clk); if (rsp_valid) seen = 1'b1; end
    check("arst.no_rsp", 32'(seen), 32'd0);
    v = '{"arst_rd300", 1'b0, 32'h300, 32'h0, 0, 0, 0, 1'b0, 32'hFFFF_FCFF, 3};
    run_vec(v);
    v = '{"arst_rd10", 1'b0, 32'h10, 32'h0, 0, 0, 0, 1'b0, 32'hCAFE_F00D, 3};
    run_vec(v);

    check("protocol.violations", 32'(viol), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/host_bus_master.md
Name: host_bus_master

Overview:
- Host-side initiator for the systolic-array accelerator's memory-mapped control bus.
- Drives the AW/W/AR/R channels that the accelerator controller responds to.
- Converts single-beat word commands (write or read) from a simple valid/ready command port into correctly ordered bus handshakes.
- Returns completion, read data and a timeout error on a response port. Used by testbenches and by a host/DMA wrapper to program scratchpad data, matmul addresses and start, and to read back results.

Parameters:
- TIMEOUT_CYCLES, 1024: max cycles waited for any single channel handshake; 0 disables the timeout.
- TCNT_W, 16: width of the timeout counter; must satisfy TIMEOUT_CYCLES < 2**TCNT_W.

Ports:
- clk  in  1  clock, all logic on rising edge
- n_rst  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  32  byte address (word_t)
- cmd_wdata  in  32  write data (ignored for reads)
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
- rsp_write  out  1  response belongs to a write
- rsp_err  out  1  channel handshake timed out
- rsp_data  out  32  read data; 0 for writes and errors
- busy  out  1  high in every state except IDLE
- AWVALID  out  1  write address valid
- AWADDR  out  32  write address
- AWREADY  in  1  write address ready
- WDVALID  out  1  write data valid
- WDATA  out  32  write data
- WDREADY  in  1  write data ready
- ARVALID  out  1  read address valid
- ARADDR  out  32  read address
- ARREADY  in  1  read address ready
- RDREADY  out  1  read data ready
- RDVALID  in  1  read data valid
- RDATA  in  32  read data

Behaviour:
- Reset (async, n_rst=0):
  - state=IDLE.
  - All VALID/READY outputs, rsp_valid, rsp_err, rsp_write and busy are 0.
  - AWADDR, WDATA, ARADDR and rsp_data are 0.
  - Timeout counter is 0.
  - Reset mid-transaction abandons the transaction and produces no response.
- FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_DATA, RESP.
  - IDLE: cmd_ready=1. On accept, register addr/wdata/write flag; go to WR_ADDR (write) or RD_ADDR (read).
  - WR_ADDR: AWVALID=1, AWADDR held stable. On AWREADY at an edge, go to WR_DATA.
  - WR_DATA: WDVALID=1, WDATA held stable. On WDREADY, go to RESP with rsp_write=1, rsp_err=0, rsp_data=0.
  - RD_ADDR: ARVALID=1, ARADDR held stable. On ARREADY, go to RD_DATA.
  - RD_DATA: RDREADY=1. On RDVALID, capture RDATA into rsp_data and go to RESP with rsp_write=0, rsp_err=0.
  - RESP: rsp_valid=1, fields held stable. On rsp_ready, go to IDLE.
- Channel ordering:
  - Strictly one outstanding command; cmd_ready=0 outside IDLE.
  - AW always completes before W is asserted.
  - No write-response channel exists; a write is complete at the W handshake.
- Valid rules:
  - A VALID output, once asserted, never deasserts before its handshake, except on timeout or reset.
  - VALID never waits on READY.
  - A READY input already high in the first cycle of a state completes the handshake that same edge.
- Latency (zero-wait responder):
  - Write: accept edge E, AWVALID during E+1, WDVALID during E+2, rsp_valid during E+3.
  - Read: the same shape; ARVALID during E+1, RDREADY during E+2, rsp_valid during E+3.
  - Back-to-back commands: the next cmd_ready is high one cycle after the rsp handshake; minimum command period is 4 cycles.
- Timeout:
  - Counter clears on entry to WR_ADDR, WR_DATA, RD_ADDR and RD_DATA, and increments each cycle in those states without a handshake.
  - When the count reaches TIMEOUT_CYCLES-1 and there is no handshake that edge, drop the active VALID/READY and go to RESP with rsp_err=1, rsp_data=0, and rsp_write set to the command type.
  - A handshake on the same edge as the limit wins; no error is raised.
  - Not active in IDLE or RESP; RESP waits indefinitely for rsp_ready.
- Response stalling: rsp_ready low holds RESP and keeps cmd_ready=0. No command is lost or buffered.
- Spurious inputs: AWREADY, WDREADY, ARREADY and RDVALID outside their matching state are ignored, and RDATA is ignored outside RD_DATA.

Test Plan:
- Write, zero-wait: cmd write addr=0x0000_0010, data=0xCAFE_F00D, all READY tied high -> AWVALID at E+1 with AWADDR=0x10; WDVALID at E+2 with WDATA=0xCAFEF00D; rsp_valid at E+3 with rsp_write=1, rsp_err=0, rsp_data=0.
- Read with waits: cmd read addr=0x40, ARREADY delayed 3 cycles, RDVALID delayed 2 cycles with RDATA=0x1234_5678 -> ARVALID/ARADDR stable for 4 cycles; RDREADY held; rsp_data=0x12345678, rsp_err=0.
- Timeout: TIMEOUT_CYCLES=8, write with AWREADY stuck 0 -> AWVALID high exactly 8 cycles then drops; WDVALID never asserts; rsp_err=1, rsp_write=1; same check for RDVALID stuck 0 on a read.
- Response backpressure: rsp_ready=0 for 5 cycles with cmd_valid held -> rsp fields stable, cmd_ready=0; the next command is accepted one cycle after the rsp handshake.
- Back-to-back: write 0xA to 0x100, then read 0x100 with the model returning 0xA -> correct AW-before-W order; rsp_data=0xA; 4-cycle command period.
- Async reset: assert n_rst during WR_DATA -> WDVALID, busy and rsp_valid drop immediately with no clock edge; no response after release; cmd_ready=1 one cycle after reset release.
